// File: rtl/lms_pkg.sv
// -----------------------------------------------------------------------------
// lms_pkg
// Shared definitions for the LMS coefficient-update block:
//   - lms_state_t   : controller state encoding (IDLE/UPDATE/RELOAD/STREAM)
//   - width constants derived from the data width
//   - sat_to_data() : saturate a wide signed value into the data width
//   - clamp_taps()  : effective tap count = min(tap_count, max_taps)
// -----------------------------------------------------------------------------
package lms_pkg;

    localparam int LMS_DATA_W   = 32;
    localparam int LMS_WIDE_W   = 2 * LMS_DATA_W;
    localparam int LMS_MAX_TAPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_RELOAD = 2'd2,
        ST_STREAM = 2'd3
    } lms_state_t;

    // A wide value fits in the data width when every bit from the data sign
    // bit upward agrees; otherwise clip to the extreme of matching sign.
    function automatic logic [LMS_DATA_W-1:0] sat_to_data(
        input logic signed [LMS_WIDE_W-1:0] v
    );
        logic [LMS_WIDE_W-LMS_DATA_W:0] top;
        top = v[LMS_WIDE_W-1:LMS_DATA_W-1];
        if ((&top) || (~|top)) begin
            return v[LMS_DATA_W-1:0];
        end else if (v[LMS_WIDE_W-1]) begin
            return {1'b1, {(LMS_DATA_W-1){1'b0}}};
        end else begin
            return {1'b0, {(LMS_DATA_W-1){1'b1}}};
        end
    endfunction

    function automatic logic [31:0] clamp_taps(
        input logic [31:0] tap_count,
        input logic [31:0] max_taps
    );
        return (tap_count > max_taps) ? max_taps : tap_count;
    endfunction

endpackage

// File: rtl/lms_sample_history.sv
// -----------------------------------------------------------------------------
// lms_sample_history
// Input-sample history for the LMS update. r_hist shifts on every x strobe
// with entry 0 holding the newest sample. On i_snap the whole history is
// copied into r_snap, so the update walks a frozen set of samples while new
// x samples keep arriving.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_x_valid/i_x_data new input sample
//   i_snap            copy live history into the snapshot
//   i_rd_idx          snapshot read index
//   o_rd_data         snapshot[i_rd_idx] (combinational)
// -----------------------------------------------------------------------------
module lms_sample_history
    import lms_pkg::*;
#(
    parameter int MAX_TAPS = LMS_MAX_TAPS,
    parameter int DATA_W   = LMS_DATA_W,
    parameter int IDX_W    = $clog2(MAX_TAPS)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_x_valid,
    input  logic [DATA_W-1:0] i_x_data,
    input  logic              i_snap,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_hist [MAX_TAPS];
    logic [DATA_W-1:0] r_snap [MAX_TAPS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < MAX_TAPS; i++) begin
                r_hist[i] <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            // The snapshot takes the history as it stood before this cycle's
            // shift; a sample arriving in the pairing cycle belongs to the
            // next output.
            if (i_snap) begin
                for (int i = 0; i < MAX_TAPS; i++) begin
                    r_snap[i] <= r_hist[i];
                end
            end
            if (i_x_valid) begin
                r_hist[0] <= i_x_data;
                for (int i = 1; i < MAX_TAPS; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
        end
    end

    assign o_rd_data = r_snap[i_rd_idx];

endmodule

// File: rtl/lms_coeff_update.sv
// -----------------------------------------------------------------------------
// lms_coeff_update
// Adaptive stage after the FIR. Pairs each FIR output y with its desired
// sample d, forms e = sat(d - y), updates its weight copy one tap per cycle
// with w[i] = sat(w[i] + sat((e * x[i]) >>> mu_shift)), then pulses
// o_coeff_reload and streams w[0..N-1] into the FIR coefficient load port.
//
// Handshake: all strobes are single-cycle valids with no back-pressure.
// y and d each park in a one-entry holder; a strobe that finds its holder
// full is dropped and sets the sticky o_overrun. Strobes with i_enable=0 are
// ignored. A pair is consumed on the first IDLE cycle where both are present,
// including strobes arriving in that same cycle.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_enable                gate for accepting y/d strobes
//   i_tap_count             requested taps, clamped to MAX_TAPS
//   i_mu_shift              step-size right shift
//   i_x_valid/i_x_data      input sample stream (same as FIR input)
//   i_y_valid/i_y_data      FIR output
//   i_d_valid/i_d_data      desired sample
//   o_error_valid/o_error_data   saturated error, data holds between strobes
//   o_coeff_reload          one-cycle pulse ahead of the coefficient stream
//   o_coeff_valid/o_coeff_data   coefficient stream, w[0] first
//   o_busy                  update or stream in progress
//   o_overrun               sticky, a y or d strobe was dropped
//   o_state                 controller state, for observation
// -----------------------------------------------------------------------------
module lms_coeff_update
    import lms_pkg::*;
#(
    parameter int MAX_TAPS = LMS_MAX_TAPS,
    parameter int DATA_W   = LMS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [31:0]       i_tap_count,
    input  logic [5:0]        i_mu_shift,
    input  logic              i_x_valid,
    input  logic [DATA_W-1:0] i_x_data,
    input  logic              i_y_valid,
    input  logic [DATA_W-1:0] i_y_data,
    input  logic              i_d_valid,
    input  logic [DATA_W-1:0] i_d_data,
    output logic              o_error_valid,
    output logic [DATA_W-1:0] o_error_data,
    output logic              o_coeff_reload,
    output logic              o_coeff_valid,
    output logic [DATA_W-1:0] o_coeff_data,
    output logic              o_busy,
    output logic              o_overrun,
    output lms_state_t        o_state
);

    localparam int IDX_W  = $clog2(MAX_TAPS);
    localparam int NW     = IDX_W + 1;
    localparam int WIDE_W = 2 * DATA_W;

    // ---------------------------------------------------------------- state
    lms_state_t r_state;
    lms_state_t w_state_nxt;

    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_d;
    logic              r_y_full;
    logic              r_d_full;
    logic              r_overrun;

    logic [DATA_W-1:0] r_err;
    logic              r_err_valid;
    logic [5:0]        r_mu;
    logic [NW-1:0]     r_n;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_w [MAX_TAPS];
    logic [DATA_W-1:0] r_coeff_data;

    // ------------------------------------------------------- y/d pairing
    logic              w_y_acc;
    logic              w_d_acc;
    logic              w_y_drop;
    logic              w_d_drop;
    logic [DATA_W-1:0] w_y_val;
    logic [DATA_W-1:0] w_d_val;
    logic              w_pair;
    logic [NW-1:0]     w_n;
    logic [DATA_W-1:0] w_err;
    logic [WIDE_W-1:0] w_err_wide;

    assign w_y_acc  = i_y_valid & i_enable & ~r_y_full;
    assign w_d_acc  = i_d_valid & i_enable & ~r_d_full;
    assign w_y_drop = i_y_valid & i_enable & r_y_full;
    assign w_d_drop = i_d_valid & i_enable & r_d_full;

    // A held value takes priority; otherwise the strobe arriving now is used.
    assign w_y_val = r_y_full ? r_y : i_y_data;
    assign w_d_val = r_d_full ? r_d : i_d_data;

    assign w_pair = (r_state == ST_IDLE) &&
                    (r_y_full || w_y_acc) && (r_d_full || w_d_acc);

    assign w_n = NW'(clamp_taps(i_tap_count, 32'(MAX_TAPS)));

    assign w_err_wide = {{DATA_W{w_d_val[DATA_W-1]}}, w_d_val}
                      - {{DATA_W{w_y_val[DATA_W-1]}}, w_y_val};
    assign w_err      = sat_to_data(w_err_wide);

    // ------------------------------------------------------ tap update
    logic [DATA_W-1:0]        w_x_snap;
    logic [DATA_W-1:0]        w_w_cur;
    logic signed [WIDE_W-1:0] w_prod;
    logic signed [WIDE_W-1:0] w_shifted;
    logic [DATA_W-1:0]        w_delta;
    logic signed [WIDE_W-1:0] w_sum;
    logic [DATA_W-1:0]        w_w_new;
    logic                     w_last;

    lms_sample_history #(
        .MAX_TAPS (MAX_TAPS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_hist (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_x_valid (i_x_valid),
        .i_x_data  (i_x_data),
        .i_snap    (w_pair),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_x_snap)
    );

    assign w_w_cur = r_w[r_idx];

    // Both operands are sign-extended to the full product width, so the low
    // WIDE_W bits of the product are the exact signed product.
    assign w_prod    = $signed({{DATA_W{r_err[DATA_W-1]}}, r_err})
                     * $signed({{DATA_W{w_x_snap[DATA_W-1]}}, w_x_snap});
    // Arithmetic shift of a signed value rounds toward negative infinity.
    assign w_shifted = w_prod >>> r_mu;
    assign w_delta   = sat_to_data(w_shifted);
    assign w_sum     = $signed({{DATA_W{w_w_cur[DATA_W-1]}}, w_w_cur})
                     + $signed({{DATA_W{w_delta[DATA_W-1]}}, w_delta});
    assign w_w_new   = sat_to_data(w_sum);

    // r_n is at least 1 whenever UPDATE or STREAM is active.
    assign w_last = ({1'b0, r_idx} == (r_n - NW'(1)));

    // ---------------------------------------------------- FSM register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------- FSM next state and outputs
    always_comb begin
        w_state_nxt    = r_state;
        o_coeff_reload = 1'b0;
        o_coeff_valid  = 1'b0;
        o_busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                // A zero tap count still reports the error but skips the
                // update and stream entirely.
                if (w_pair && (w_n != '0)) begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (w_last) begin
                    w_state_nxt = ST_RELOAD;
                end
            end
            ST_RELOAD: begin
                o_coeff_reload = 1'b1;
                w_state_nxt    = ST_STREAM;
            end
            ST_STREAM: begin
                o_coeff_valid = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------- datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_y          <= '0;
            r_d          <= '0;
            r_y_full     <= 1'b0;
            r_d_full     <= 1'b0;
            r_overrun    <= 1'b0;
            r_err        <= '0;
            r_err_valid  <= 1'b0;
            r_mu         <= '0;
            r_n          <= '0;
            r_idx        <= '0;
            r_coeff_data <= '0;
            for (int i = 0; i < MAX_TAPS; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            r_err_valid <= 1'b0;
            r_overrun   <= r_overrun | w_y_drop | w_d_drop;

            // Holders: emptied by a pairing, otherwise filled by an accepted
            // strobe. Refilling is allowed while the update is running.
            if (w_pair) begin
                r_y_full <= 1'b0;
                r_d_full <= 1'b0;
            end else begin
                if (w_y_acc) begin
                    r_y_full <= 1'b1;
                    r_y      <= i_y_data;
                end
                if (w_d_acc) begin
                    r_d_full <= 1'b1;
                    r_d      <= i_d_data;
                end
            end

            // Tap count and step size are frozen at pairing time.
            if (w_pair) begin
                r_err       <= w_err;
                r_err_valid <= 1'b1;
                r_mu        <= i_mu_shift;
                r_n         <= w_n;
            end

            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                end
                ST_UPDATE: begin
                    r_w[r_idx] <= w_w_new;
                    r_idx      <= w_last ? '0 : r_idx + 1'b1;
                end
                ST_RELOAD: begin
                    // Preload the first coefficient so it is on the port in
                    // the first STREAM cycle.
                    r_coeff_data <= r_w[0];
                    r_idx        <= '0;
                end
                ST_STREAM: begin
                    if (!w_last) begin
                        r_coeff_data <= r_w[r_idx + 1'b1];
                        r_idx        <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign o_error_valid = r_err_valid;
    assign o_error_data  = r_err;
    assign o_coeff_data  = r_coeff_data;
    assign o_overrun     = r_overrun;
    assign o_state       = r_state;

endmodule
